// File: rtl/rt_pkg.sv
// rtl/rt_pkg.sv - shared constants, FSM encoding and helpers for the routing-table lookup arbiter
package rt_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int NH_WIDTH   = 9;

    typedef enum logic {
        RT_ARB_WAIT_CFG = 1'b0,
        RT_ARB_RUN      = 1'b1
    } rt_arb_state_e;

    // Ceiling log2, used to size the round-robin pointer.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker
// Ports:
//   req_i    : request vector, one bit per requester
//   ptr_i    : highest-priority requester index this cycle
//   gnt_o    : one-hot grant (zero when no request)
//   winner_o : index of the granted requester (zero when no request)
//   any_o    : at least one request present
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   winner_o,
    output logic               any_o
);

    int idx;

    // Scan from ptr_i upward with wrap; the first asserted request wins.
    always_comb begin
        winner_o = '0;
        any_o    = 1'b0;
        idx      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr_i) + i) % NUM_REQ;
            if (!any_o && req_i[idx]) begin
                any_o    = 1'b1;
                winner_o = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            gnt_o[j] = any_o && (int'(winner_o) == j);
        end
    end

endmodule

// File: rtl/rt_lookup_arbiter.sv
// rtl/rt_lookup_arbiter.sv - round-robin sharing of routing-table port B with response routing
// Optional feature macro: RT_ARB_STATS_EN (grant/stall statistics counters)
// Ports:
//   clock, reset      : single clock, synchronous active-high reset
//   enable            : global enable; freezes arbitration and the lookup pipeline
//   cfg_done          : table configuration complete; grants only while set
//   req, req_dest     : per-requester lookup request and packed destination
//   gnt               : one-hot combinational grant
//   tbl_dest          : address to table port B (0 when no grant)
//   tbl_nexthop       : table port B read data
//   rsp_valid         : one-hot registered response pulse
//   rsp_nexthop       : shared response data, holds when idle
//   busy              : lookups in flight
//   stat_grants       : (RT_ARB_STATS_EN) per-requester saturating grant counts
//   stat_stall        : (RT_ARB_STATS_EN) saturating count of requested-but-not-granted cycles
module rt_lookup_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = rt_pkg::ADDR_WIDTH,
    parameter int NH_WIDTH   = rt_pkg::NH_WIDTH,
    parameter int RD_LAT     = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          cfg_done,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_dest,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NH_WIDTH-1:0]           rsp_nexthop,
    output logic [ADDR_WIDTH-1:0]         tbl_dest,
    input  logic [NH_WIDTH-1:0]           tbl_nexthop,
    output logic                          busy
`ifdef RT_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]         stat_grants,
    output logic [15:0]                   stat_stall
`endif
);

    import rt_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;

    rt_arb_state_e state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [PTR_W-1:0]   arb_winner;
    logic               arb_any;
    logic               grant_ok;
    logic               grant_fire;

    logic [RD_LAT-1:0]              stage_vld_q;
    logic [RD_LAT-1:0][NUM_REQ-1:0] stage_id_q;
    logic [NUM_REQ-1:0]             rsp_valid_q;
    logic [NH_WIDTH-1:0]            rsp_nexthop_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req_i    (req),
        .ptr_i    (rr_ptr_q),
        .gnt_o    (arb_gnt),
        .winner_o (arb_winner),
        .any_o    (arb_any)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= RT_ARB_WAIT_CFG;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RT_ARB_WAIT_CFG: if (cfg_done)  state_d = RT_ARB_RUN;
            RT_ARB_RUN:      if (!cfg_done) state_d = RT_ARB_WAIT_CFG;
            default:         state_d = RT_ARB_WAIT_CFG;
        endcase
    end

    // cfg_done is checked directly so a table reload stops grants in the
    // same cycle it is seen, not one cycle later when the FSM follows.
    assign grant_ok   = !reset && (state_q == RT_ARB_RUN) && cfg_done && enable;
    assign grant_fire = grant_ok && arb_any;
    assign gnt        = grant_ok ? arb_gnt : '0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_fire) begin
            if (int'(arb_winner) == NUM_REQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = arb_winner + PTR_W'(1);
            end
        end
    end

    always_comb begin
        tbl_dest = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                tbl_dest = req_dest[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // The id shift register tracks the table's read latency; it advances on
    // exactly the cycles the table advances (enable=1) so id and data stay aligned.
    always_ff @(posedge clock) begin
        if (reset) begin
            stage_vld_q   <= '0;
            stage_id_q    <= '0;
            rsp_valid_q   <= '0;
            rsp_nexthop_q <= '0;
        end else if (enable) begin
            stage_vld_q[0] <= grant_fire;
            stage_id_q[0]  <= gnt;
            for (int k = 1; k < RD_LAT; k++) begin
                stage_vld_q[k] <= stage_vld_q[k-1];
                stage_id_q[k]  <= stage_id_q[k-1];
            end
            rsp_valid_q <= stage_vld_q[RD_LAT-1] ? stage_id_q[RD_LAT-1] : '0;
            if (stage_vld_q[RD_LAT-1]) begin
                rsp_nexthop_q <= tbl_nexthop;
            end
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_nexthop = rsp_nexthop_q;
    assign busy        = (|stage_vld_q) || (|rsp_valid_q);

`ifdef RT_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] grants_q;
    logic [15:0]              stall_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            grants_q <= '0;
            stall_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] && (grants_q[i] != 16'hFFFF)) begin
                    grants_q[i] <= grants_q[i] + 16'd1;
                end
            end
            if ((|req) && !grant_fire && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign stat_grants = grants_q;
    assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_rt_lookup_arbiter.sv
// tb/tb_rt_lookup_arbiter.sv - directed self-checking bench for rt_lookup_arbiter
module tb_rt_lookup_arbiter;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        cfg_done;
    logic [3:0]  req;
    logic [31:0] req_dest;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic [8:0]  rsp_nexthop;
    logic [7:0]  tbl_dest;
    logic [8:0]  tbl_nexthop;
    logic        busy;
`ifdef RT_ARB_STATS_EN
    logic [63:0] stat_grants;
    logic [15:0] stat_stall;
`endif

    int total;
    int bad;

    logic [8:0] mem [256];
    logic [7:0] dests [4];

    rt_lookup_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .cfg_done    (cfg_done),
        .req         (req),
        .req_dest    (req_dest),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_nexthop (rsp_nexthop),
        .tbl_dest    (tbl_dest),
        .tbl_nexthop (tbl_nexthop),
        .busy        (busy)
`ifdef RT_ARB_STATS_EN
        ,
        .stat_grants (stat_grants),
        .stat_stall  (stat_stall)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Table port B model: one-cycle read latency, reads only when enabled.
    initial tbl_nexthop = '0;
    always @(posedge clock) begin
        if (enable) tbl_nexthop <= mem[tbl_dest];
    end

    function automatic logic [8:0] nh(input logic [7:0] a);
        if (a == 8'h3C) return 9'h1A5;
        return {1'b1, a} ^ 9'h0A3;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; cfg_done = 1'b1; req = 4'b1111;
        tick();
        tick();
        @(negedge clock);
        total++;
        if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        tick();
        reset = 1'b0; cfg_done = 1'b0; req = 4'b0000;
        @(negedge clock);
        total++;
        if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
        total++;
        if (rsp_nexthop !== 9'h000) begin bad++; $display("FAIL reset_rsp_nexthop: got %h want 000", rsp_nexthop); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++;
        if (tbl_dest !== 8'h00) begin bad++; $display("FAIL reset_tbl_dest: got %h want 00", tbl_dest); end
    endtask

    task automatic test_cfg_gating();
        for (int c = 0; c < 10; c++) begin
            tick();
            req = 4'b1111; cfg_done = 1'b0;
            @(negedge clock);
            total++;
            if (gnt !== 4'b0000 || rsp_valid !== 4'b0000) begin
                bad++; $display("FAIL cfg_wait cycle %0d: gnt=%b rsp=%b want 0000/0000", c, gnt, rsp_valid);
            end
        end
        tick();
        cfg_done = 1'b1;
        @(negedge clock);
        total++;
        if (gnt !== 4'b0000) begin bad++; $display("FAIL cfg_raise_same_cycle: got %b want 0000", gnt); end
        tick();
        @(negedge clock);
        total++;
        if (gnt !== 4'b0001) begin bad++; $display("FAIL cfg_first_gnt: got %b want 0001", gnt); end
        total++;
        if (tbl_dest !== dests[0]) begin bad++; $display("FAIL cfg_tbl_dest: got %h want %h", tbl_dest, dests[0]); end
        tick();
        req = 4'b0000;
        @(negedge clock);
        total++;
        if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL cfg_rsp_early: got %b want 0000", rsp_valid); end
        tick();
        @(negedge clock);
        total++;
        if (rsp_valid !== 4'b0001 || rsp_nexthop !== nh(dests[0])) begin
            bad++; $display("FAIL cfg_rsp: got %b/%h want 0001/%h", rsp_valid, rsp_nexthop, nh(dests[0]));
        end
    endtask

    task automatic do_reset_run();
        tick();
        reset = 1'b1; cfg_done = 1'b1; req = 4'b0000; enable = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        int win [5] = '{0, 1, 2, 3, 0};
        logic [3:0] g;
        for (int k = 0; k < 8; k++) begin
            tick();
            req = (k < 5) ? 4'b1111 : 4'b0000;
            @(negedge clock);
            if (k < 5) begin
                g = 4'b0001 << win[k];
                total++;
                if (gnt !== g || tbl_dest !== dests[win[k]]) begin
                    bad++; $display("FAIL rr_gnt step %0d: got %b/%h want %b/%h", k, gnt, tbl_dest, g, dests[win[k]]);
                end
            end
            if (k >= 2 && k < 7) begin
                g = 4'b0001 << win[k-2];
                total++;
                if (rsp_valid !== g || rsp_nexthop !== nh(dests[win[k-2]])) begin
                    bad++; $display("FAIL rr_rsp step %0d: got %b/%h want %b/%h", k, rsp_valid, rsp_nexthop, g, nh(dests[win[k-2]]));
                end
            end else begin
                total++;
                if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL rr_rsp_idle step %0d: got %b want 0000", k, rsp_valid); end
            end
            if (k == 1) begin
                total++;
                if (busy !== 1'b1) begin bad++; $display("FAIL rr_busy: got %b want 1", busy); end
            end
            if (k == 7) begin
                total++;
                if (busy !== 1'b0) begin bad++; $display("FAIL rr_idle_busy: got %b want 0", busy); end
            end
        end
    endtask

    task automatic test_data_path();
        tick();
        req = 4'b0100;
        @(negedge clock);
        total++;
        if (gnt !== 4'b0100 || tbl_dest !== 8'h3C) begin bad++; $display("FAIL dp_gnt: got %b/%h want 0100/3c", gnt, tbl_dest); end
        tick();
        req = 4'b0000;
        @(negedge clock);
        total++;
        if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL dp_rsp_early: got %b want 0000", rsp_valid); end
        tick();
        @(negedge clock);
        total++;
        if (rsp_valid !== 4'b0100 || rsp_nexthop !== 9'h1A5) begin
            bad++; $display("FAIL dp_rsp: got %b/%h want 0100/1a5", rsp_valid, rsp_nexthop);
        end
        tick();
        @(negedge clock);
        total++;
        if (rsp_valid !== 4'b0000 || rsp_nexthop !== 9'h1A5) begin
            bad++; $display("FAIL dp_hold: got %b/%h want 0000/1a5", rsp_valid, rsp_nexthop);
        end
    endtask

    task automatic test_enable_stall();
        tick();
        req = 4'b0010;
        @(negedge clock);
        total++;
        if (gnt !== 4'b0010) begin bad++; $display("FAIL stall_gnt: got %b want 0010", gnt); end
        for (int s = 0; s < 3; s++) begin
            tick();
            enable = 1'b0; req = 4'b1111;
            @(negedge clock);
            total++;
            if (gnt !== 4'b0000 || rsp_valid !== 4'b0000) begin
                bad++; $display("FAIL stall_frozen cycle %0d: gnt=%b rsp=%b want 0000/0000", s, gnt, rsp_valid);
            end
        end
        tick();
        enable = 1'b1; req = 4'b0000;
        @(negedge clock);
        total++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin
            bad++; $display("FAIL stall_resume: rsp=%b busy=%b want 0000/1", rsp_valid, busy);
        end
        tick();
        @(negedge clock);
        total++;
        if (rsp_valid !== 4'b0010 || rsp_nexthop !== nh(dests[1])) begin
            bad++; $display("FAIL stall_rsp: got %b/%h want 0010/%h", rsp_valid, rsp_nexthop, nh(dests[1]));
        end
    endtask

    task automatic test_reload();
        tick();
        req = 4'b0010;
        @(negedge clock);
        total++;
        if (gnt !== 4'b0010) begin bad++; $display("FAIL reload_gnt: got %b want 0010", gnt); end
        tick();
        cfg_done = 1'b0; req = 4'b1111;
        @(negedge clock);
        total++;
        if (gnt !== 4'b0000) begin bad++; $display("FAIL reload_stop: got %b want 0000", gnt); end
        tick();
        @(negedge clock);
        total++;
        if (gnt !== 4'b0000 || rsp_valid !== 4'b0010 || rsp_nexthop !== nh(dests[1])) begin
            bad++; $display("FAIL reload_rsp: got %b/%b/%h want 0000/0010/%h", gnt, rsp_valid, rsp_nexthop, nh(dests[1]));
        end
        tick();
        @(negedge clock);
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL reload_idle: gnt=%b busy=%b want 0000/0", gnt, busy); end
        tick();
        cfg_done = 1'b1;
        @(negedge clock);
        total++;
        if (gnt !== 4'b0000) begin bad++; $display("FAIL reload_wait_state: got %b want 0000", gnt); end
        tick();
        @(negedge clock);
        total++;
        if (gnt !== 4'b0100) begin bad++; $display("FAIL reload_resume_gnt: got %b want 0100", gnt); end
        tick();
        req = 4'b0000;
        tick();
        @(negedge clock);
        total++;
        if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL reload_resume_rsp: got %b want 0100", rsp_valid); end
    endtask

    task automatic test_reset_midflight();
        tick();
        req = 4'b1111;
        @(negedge clock);
        total++;
        if (gnt !== 4'b1000) begin bad++; $display("FAIL rst_mf_gnt0: got %b want 1000", gnt); end
        tick();
        @(negedge clock);
        total++;
        if (gnt !== 4'b0001) begin bad++; $display("FAIL rst_mf_gnt1: got %b want 0001", gnt); end
        tick();
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b1) begin bad++; $display("FAIL rst_mf_during: gnt=%b busy=%b want 0000/1", gnt, busy); end
        tick();
        reset = 1'b0; req = 4'b0000; cfg_done = 1'b1;
        @(negedge clock);
        total++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_mf_dropped: rsp=%b busy=%b want 0000/0", rsp_valid, busy);
        end
`ifdef RT_ARB_STATS_EN
        total++;
        if (stat_grants !== 64'h0 || stat_stall !== 16'h0) begin
            bad++; $display("FAIL rst_mf_stats: grants=%h stall=%h want 0/0", stat_grants, stat_stall);
        end
`endif
        tick();
        @(negedge clock);
        total++;
        if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL rst_mf_no_rsp: got %b want 0000", rsp_valid); end
        tick();
        req = 4'b1111;
        @(negedge clock);
        total++;
        if (gnt !== 4'b0001) begin bad++; $display("FAIL rst_mf_ptr0: got %b want 0001", gnt); end
        tick();
        req = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) mem[i] = nh(i[7:0]);
        dests[0] = 8'h10; dests[1] = 8'h21; dests[2] = 8'h3C; dests[3] = 8'h47;
        req_dest = {dests[3], dests[2], dests[1], dests[0]};
        reset = 1'b1; enable = 1'b1; cfg_done = 1'b0; req = 4'b0000;

        test_reset();
        test_cfg_gating();
        do_reset_run();
        test_round_robin();
        test_data_path();
        test_enable_stall();
        test_reload();
        test_reset_midflight();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
